// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant locking and an optional
// maximum-hold limit that forces rotation when other requesters are waiting.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             preempt_q, preempt_d;

    logic [3:0] others;
    logic [2:0] pick_idle, pick_busy;
    logic       release_c, forced_c;

    // Returns {found, index}: first set bit of r searching from p upward, mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            cand = p + 2'(i);
            if (r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        preempt_d   = 1'b0;

        others    = req & ~(4'b0001 << gnt_idx_q);
        pick_idle = rr_pick(req, ptr_q);
        pick_busy = rr_pick(others, ptr_q);
        release_c = done[gnt_idx_q] | ~req[gnt_idx_q];
        forced_c  = (MAX_HOLD != 0) && (hold_cnt_q == MAX_HOLD_C) && (others != 4'b0000);

        case (state_q)
            IDLE: begin
                if (pick_idle[2]) begin
                    gnt_d       = 4'b0001 << pick_idle[1:0];
                    gnt_idx_d   = pick_idle[1:0];
                    gnt_valid_d = 1'b1;
                    ptr_d       = pick_idle[1:0] + 2'd1;
                    hold_cnt_d  = CNT_W'(1);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if ((release_c || forced_c) && pick_busy[2]) begin
                    // Direct hand-over: no idle bubble between owners.
                    gnt_d       = 4'b0001 << pick_busy[1:0];
                    gnt_idx_d   = pick_busy[1:0];
                    gnt_valid_d = 1'b1;
                    ptr_d       = pick_busy[1:0] + 2'd1;
                    hold_cnt_d  = CNT_W'(1);
                    preempt_d   = forced_c & ~release_c;
                end else if (release_c) begin
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    state_d     = IDLE;
                end else if (hold_cnt_q < MAX_HOLD_C) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            hold_cnt_q  <= '0;
            gnt_q       <= 4'b0000;
            gnt_idx_q   <= 2'd0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 (MAX_HOLD=8) plus a random invariant sweep.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_total = 0;
    int n_pass  = 0;

    rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] idx,
                             input logic v, input logic p);
        chk({tag, ".gnt"}, gnt, g);
        chk({tag, ".idx"}, {2'b00, gnt_idx}, {2'b00, idx});
        chk({tag, ".valid"}, {3'b000, gnt_valid}, {3'b000, v});
        chk({tag, ".preempt"}, {3'b000, preempt}, {3'b000, p});
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 4'b0000;
        #12;
        chk_grant("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Single request, release by done
        req = 4'b0100;
        tick();
        chk_grant("single", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk("single_hold", gnt, 4'b0100);
        done = 4'b0100;
        tick();
        chk_grant("single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
        req  = 4'b0000;
        done = 4'b0000;
        tick();

        // Round-robin order 0,1,2,3,0 with back-to-back hand-over
        pulse_reset();
        req = 4'b1111;
        tick();
        chk_grant("rr0", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 4'b0001; tick(); done = 4'b0000;
        chk_grant("rr1", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 4'b0010; tick(); done = 4'b0000;
        chk_grant("rr2", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 4'b0100; tick(); done = 4'b0000;
        chk_grant("rr3", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 4'b1000; tick(); done = 4'b0000;
        chk_grant("rr0b", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk("rr_idle", gnt, 4'b0000);

        // Forced rotation after 8 cycles of ownership
        pulse_reset();
        req = 4'b0011;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk_grant($sformatf("hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        tick();
        chk_grant("preempt", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick();
        chk_grant("preempt_end", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk("pre_idle", gnt, 4'b0000);

        // Lone owner never preempted
        req = 4'b0001;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_grant($sformatf("lone%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        req = 4'b0000;
        tick();
        chk("lone_idle", {3'b000, gnt_valid}, 4'b0000);

        // Release by req drop, then pointer wrap (ptr=1 here)
        req = 4'b1000;
        tick();
        chk_grant("drop_own3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b1001;
        tick();
        chk("drop_hold", gnt, 4'b1000);
        req = 4'b0001;
        tick();
        chk_grant("drop_to0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req  = 4'b1001;
        done = 4'b0001;
        tick();
        chk_grant("wrap_to3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req  = 4'b0000;
        done = 4'b0000;
        tick();

        // Asynchronous reset mid-grant
        req = 4'b0010;
        tick();
        chk("async_pre", gnt, 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        chk_grant("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        req = 4'b1111;
        tick();
        chk_grant("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Spurious done from non-owner and while idle
        done = 4'b0001;
        tick();
        chk_grant("sp_own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 4'b1000;
        tick();
        chk_grant("sp_nonowner", 4'b0010, 2'd1, 1'b1, 1'b0);
        req  = 4'b0000;
        done = 4'b0000;
        tick();
        chk("sp_idle", gnt, 4'b0000);
        done = 4'b1000;
        tick();
        chk_grant("sp_done_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        done = 4'b0000;
        req  = 4'b1111;
        tick();
        chk_grant("sp_ptr_kept", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Random sweep: one-hot, decode and valid invariants every cycle
        for (int c = 0; c < 10000; c++) begin
            req  = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            tick();
            chk("inv_onehot", {3'b000, ($countones(gnt) <= 1)}, 4'b0001);
            chk("inv_valid", {3'b000, gnt_valid}, {3'b000, (gnt != 4'b0000)});
            if (gnt_valid)
                chk("inv_decode", gnt, 4'b0001 << gnt_idx);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
